al4s3b_wb_arbiter: RTL

//  Two-master Wishbone arbiter sharing one register-block slave port (FPGA register bank).
//  M0 = AHB-to-FPGA bridge path; M1 = internal sequencer/poller. Round-robin grant, held per bus cycle.
//  A per-access ack watchdog completes hung accesses with a fixed read value and flags a sticky error.

---
 rtl/al4s3b_wb_arbiter_pkg.sv | 18 +
 rtl/al4s3b_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/al4s3b_wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone register-bank arbiter:
// FSM state encoding and master index constants.
package al4s3b_wb_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_TOUT = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   function automatic logic [1:0] owner_onehot(input logic owner);
      return (owner == M1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/al4s3b_wb_arbiter.sv
// Round-robin arbiter letting the AHB bridge (M0) and the sequencer (M1) share one
// register-bank slave, with a per-access ack watchdog and sticky per-master timeout flags.
module al4s3b_wb_arbiter
   import al4s3b_wb_arbiter_pkg::*;
#(
   parameter int                    ADDRWIDTH     = 7,
   parameter int                    DATAWIDTH     = 32,
   parameter int                    TOUT_WIDTH    = 3,
   parameter int                    TOUT_CYCLES   = 7,
   parameter logic [DATAWIDTH-1:0]  TOUT_RD_VALUE = 32'hBADFABAC
)
(
   input  logic                 WBs_CLK_i,
   input  logic                 WBs_RST_n_i,

   input  logic [ADDRWIDTH-1:0] M0_ADR_i,
   input  logic                 M0_CYC_i,
   input  logic                 M0_STB_i,
   input  logic                 M0_WE_i,
   input  logic [3:0]           M0_BYTE_STB_i,
   input  logic [DATAWIDTH-1:0] M0_DAT_i,
   output logic [DATAWIDTH-1:0] M0_DAT_o,
   output logic                 M0_ACK_o,

   input  logic [ADDRWIDTH-1:0] M1_ADR_i,
   input  logic                 M1_CYC_i,
   input  logic                 M1_STB_i,
   input  logic                 M1_WE_i,
   input  logic [3:0]           M1_BYTE_STB_i,
   input  logic [DATAWIDTH-1:0] M1_DAT_i,
   output logic [DATAWIDTH-1:0] M1_DAT_o,
   output logic                 M1_ACK_o,

   output logic [ADDRWIDTH-1:0] S_ADR_o,
   output logic                 S_CYC_o,
   output logic                 S_STB_o,
   output logic                 S_WE_o,
   output logic [3:0]           S_BYTE_STB_o,
   output logic [DATAWIDTH-1:0] S_DAT_o,
   input  logic [DATAWIDTH-1:0] S_DAT_i,
   input  logic                 S_ACK_i,

   output logic [1:0]           GRANT_o,
   output logic [1:0]           ERR_STS_o,
   input  logic [1:0]           ERR_CLR_i
);

   localparam logic [TOUT_WIDTH-1:0] TOUT_LAST = TOUT_WIDTH'(TOUT_CYCLES - 1);

   // Master inputs gathered into arrays so the owner can be selected by index.
   logic [ADDRWIDTH-1:0] m_adr      [2];
   logic                 m_cyc      [2];
   logic                 m_stb      [2];
   logic                 m_we       [2];
   logic [3:0]           m_byte_stb [2];
   logic [DATAWIDTH-1:0] m_dat      [2];

   assign m_adr[M0]      = M0_ADR_i;       assign m_adr[M1]      = M1_ADR_i;
   assign m_cyc[M0]      = M0_CYC_i;       assign m_cyc[M1]      = M1_CYC_i;
   assign m_stb[M0]      = M0_STB_i;       assign m_stb[M1]      = M1_STB_i;
   assign m_we[M0]       = M0_WE_i;        assign m_we[M1]       = M1_WE_i;
   assign m_byte_stb[M0] = M0_BYTE_STB_i;  assign m_byte_stb[M1] = M1_BYTE_STB_i;
   assign m_dat[M0]      = M0_DAT_i;       assign m_dat[M1]      = M1_DAT_i;

   arb_state_e            state, state_nxt;
   logic                  owner, owner_nxt;
   logic                  last_owner, last_owner_nxt;
   logic [TOUT_WIDTH-1:0] counter, counter_nxt;
   logic [1:0]            err_sts, err_sts_nxt;
   logic [1:0]            err_set;

   logic                  own_cyc, own_stb;
   assign own_cyc = m_cyc[owner];
   assign own_stb = m_stb[owner];

   // State register. last_owner resets to M1 so M0 wins the first tie.
   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         state      <= ST_IDLE;
         owner      <= M0;
         last_owner <= M1;
         counter    <= '0;
         err_sts    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         counter    <= counter_nxt;
         err_sts    <= err_sts_nxt;
      end
   end

   // Next-state logic: arbitration, cycle tracking and the ack watchdog.
   always_comb begin
      // NOTE: defaults first so no branch leaves a combinational output unassigned (latch).
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      counter_nxt    = counter;
      err_set        = '0;

      unique case (state)
         ST_IDLE: begin
            if (M0_CYC_i || M1_CYC_i) begin
               state_nxt   = ST_BUSY;
               counter_nxt = '0;
               if (M0_CYC_i && M1_CYC_i) owner_nxt = ~last_owner;
               else                      owner_nxt = M1_CYC_i ? M1 : M0;
            end
         end
         ST_BUSY: begin
            if (!own_cyc) begin
               state_nxt      = ST_IDLE;
               last_owner_nxt = owner;
               counter_nxt    = '0;
            end else if (S_ACK_i || !own_stb) begin
               counter_nxt = '0;
            end else if (counter == TOUT_LAST) begin
               state_nxt   = ST_TOUT;
               counter_nxt = '0;
            end else begin
               counter_nxt = counter + 1'b1;
            end
         end
         ST_TOUT: begin
            state_nxt      = ST_BUSY;
            counter_nxt    = '0;
            err_set[owner] = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A timeout flagged in the same cycle as a clear takes precedence.
      err_sts_nxt = err_set | (err_sts & ~ERR_CLR_i);
   end

   // Output logic: route the owner onto the slave port and the slave back to the owner.
   logic                 own_ack;
   logic [DATAWIDTH-1:0] own_rdat;

   always_comb begin
      S_ADR_o      = '0;
      S_CYC_o      = 1'b0;
      S_STB_o      = 1'b0;
      S_WE_o       = 1'b0;
      S_BYTE_STB_o = '0;
      S_DAT_o      = '0;
      GRANT_o      = '0;
      own_ack      = 1'b0;
      own_rdat     = '0;
      M0_ACK_o     = 1'b0;
      M0_DAT_o     = '0;
      M1_ACK_o     = 1'b0;
      M1_DAT_o     = '0;

      if (state == ST_BUSY || state == ST_TOUT) begin
         GRANT_o      = owner_onehot(owner);
         S_ADR_o      = m_adr[owner];
         S_WE_o       = m_we[owner];
         S_BYTE_STB_o = m_byte_stb[owner];
         S_DAT_o      = m_dat[owner];
         if (state == ST_BUSY) begin
            S_CYC_o  = own_cyc;
            S_STB_o  = own_stb;
            own_ack  = S_ACK_i;
            own_rdat = S_DAT_i;
         end else begin
            // Forced completion: a late slave ack in this cycle is dropped.
            own_ack  = 1'b1;
            own_rdat = TOUT_RD_VALUE;
         end
      end

      if (owner == M0) begin
         M0_ACK_o = own_ack;
         M0_DAT_o = own_rdat;
      end else begin
         M1_ACK_o = own_ack;
         M1_DAT_o = own_rdat;
      end
   end

   assign ERR_STS_o = err_sts;

endmodule
